// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and round-robin pick function for the mux_8to1 arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First asserted request at or after ptr, wrapping 7 -> 0.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] k;
    res = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    for (int unsigned off = N_REQ; off > 0; off--) begin
      k = ptr + SEL_W'(off - 1);
      if (req[k]) begin
        res.hit = 1'b1;
        res.idx = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_8to1.sv
// Combinational 8-to-1 mux: y is the data bit selected by s.
module mux_8to1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  always_comb begin
    y = i[s];
  end

endmodule

// File: rtl/mux_8to1_arbiter.sv
// Round-robin slot arbiter driving the mux_8to1 select, with a registered data bit and valid.
module mux_8to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] i,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] s,
  output logic             busy,
  output logic             y_out,
  output logic             y_valid
);

  localparam logic [3:0] CntLast = 4'(SLOT_CYCLES - 1);

  state_e           state;
  logic [SEL_W-1:0] ptr;
  logic [3:0]       cnt;
  logic             y;
  pick_t            pick;
  logic             slot_more;

  mux_8to1 u_mux (
    .i(i),
    .s(s),
    .y(y)
  );

  always_comb begin
    pick      = rr_pick(req, ptr);
    slot_more = (state == StBusy) && req[s] && (cnt < CntLast);
  end

  // Idle entry and slot boundary share one path: re-pick, else drop to idle with s held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      gnt     <= '0;
      s       <= '0;
      busy    <= 1'b0;
      y_out   <= 1'b0;
      y_valid <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      y_out   <= y;
      y_valid <= (state == StBusy) && req[s];
      if (slot_more) begin
        cnt <= cnt + 4'd1;
      end else if (pick.hit) begin
        state <= StBusy;
        busy  <= 1'b1;
        gnt   <= N_REQ'(1) << pick.idx;
        s     <= pick.idx;
        cnt   <= '0;
        ptr   <= pick.idx + SEL_W'(1);
      end else begin
        state <= StIdle;
        busy  <= 1'b0;
        gnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_8to1_arbiter.sv
// Bench for mux_8to1_arbiter: cycle model compared every cycle plus directed literal checks.
module tb_mux_8to1_arbiter;

  localparam int SLOT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] i = '0;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       busy;
  logic       y_out;
  logic       y_valid;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mux_8to1_arbiter #(
    .SLOT_CYCLES(SLOT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .i      (i),
    .gnt    (gnt),
    .s      (s),
    .busy   (busy),
    .y_out  (y_out),
    .y_valid(y_valid)
  );

  typedef struct packed {
    logic       busy;
    logic [2:0] sel;
    logic [2:0] ptr;
    logic [4:0] cnt;
    logic       yout;
    logic       yvalid;
  } model_t;

  model_t m = '0;

  // Behavioural model: winner is the requester at the smallest rotational distance from ptr.
  function automatic model_t step(model_t cur, logic [7:0] r, logic [7:0] d, logic rn);
    model_t nx;
    int     best;
    int     dist_k;
    int     dist_b;
    if (!rn) return '0;
    nx        = cur;
    nx.yout   = d[cur.sel];
    nx.yvalid = cur.busy && r[cur.sel];
    if (cur.busy && r[cur.sel] && int'(cur.cnt) < SLOT - 1) begin
      nx.cnt = cur.cnt + 5'd1;
      return nx;
    end
    best = -1;
    for (int k = 0; k < 8; k++) begin
      if (r[k]) begin
        dist_k = (k - int'(cur.ptr) + 8) % 8;
        dist_b = (best - int'(cur.ptr) + 8) % 8;
        if (best < 0 || dist_k < dist_b) best = k;
      end
    end
    if (best < 0) begin
      nx.busy = 1'b0;
    end else begin
      nx.busy = 1'b1;
      nx.sel  = 3'(best);
      nx.cnt  = '0;
      nx.ptr  = 3'((best + 1) % 8);
    end
    return nx;
  endfunction

  always @(posedge clk) m <= step(m, req, i, rst_n);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [7:0] eg;
    if (chk_en) begin
      eg = m.busy ? (8'd1 << m.sel) : 8'd0;
      check("model_gnt", 32'(gnt), 32'(eg));
      check("model_s", 32'(s), 32'(m.sel));
      check("model_busy", 32'(busy), 32'(m.busy));
      check("model_y_out", 32'(y_out), 32'(m.yout));
      check("model_y_valid", 32'(y_valid), 32'(m.yvalid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k;
    // Reset and idle
    rst_n = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_s", 32'(s), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_y_out", 32'(y_out), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_gnt", 32'(gnt), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_y_valid", 32'(y_valid), 0);
    end

    // Sole requester 2: full slot, then re-granted
    i   = 8'b0110_0110;
    req = 8'b0000_0100;
    tick();
    check("solo_s_first", 32'(s), 2);
    check("solo_gnt_first", 32'(gnt), 32'h04);
    check("solo_busy", 32'(busy), 1);
    check("solo_y_valid_lag", 32'(y_valid), 0);
    tick();
    check("solo_y_out", 32'(y_out), 1);
    check("solo_y_valid", 32'(y_valid), 1);
    tick();
    tick();
    tick();
    check("solo_regrant_s", 32'(s), 2);
    check("solo_regrant_busy", 32'(busy), 1);
    tick();
    req = 8'h00;
    tick();
    check("solo_release_gnt", 32'(gnt), 0);
    check("solo_release_busy", 32'(busy), 0);
    check("solo_release_s_hold", 32'(s), 2);
    check("solo_release_y_valid", 32'(y_valid), 0);

    // All requesting: rotation 0..7,0 with no gaps
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'hFF;
    for (int c = 1; c <= 33; c++) begin
      tick();
      k = (c - 1) / 4;
      check("rr_busy", 32'(busy), 1);
      if ((c - 1) % 4 == 0) check("rr_s", 32'(s), 32'(k % 8));
      if ((c - 1) % 4 == 1) begin
        check("rr_y_out", 32'(y_out), 32'(i[k % 8]));
        check("rr_y_valid", 32'(y_valid), 1);
      end
    end

    // Early release of 0 hands off to 4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'b0001_0001;
    tick();
    check("early_s0", 32'(s), 0);
    tick();
    check("early_s0_hold", 32'(s), 0);
    req = 8'b0001_0000;
    tick();
    check("early_s4", 32'(s), 4);
    check("early_gnt4", 32'(gnt), 32'h10);
    check("early_busy", 32'(busy), 1);
    check("early_y_valid", 32'(y_valid), 0);

    // Reset mid-slot while s = 5, then scan restarts from 0
    req   = 8'h00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'b0010_0000;
    tick();
    check("midrst_s5", 32'(s), 5);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_s", 32'(s), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_y_out", 32'(y_out), 0);
    check("midrst_y_valid", 32'(y_valid), 0);
    rst_n = 1'b1;
    req = 8'b0100_0010;
    tick();
    check("midrst_ptr0_pick", 32'(s), 1);

    // Request 3 arrives during slot of 6: no preemption
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    rst_n = 1'b1;
    req = 8'b0100_0000;
    tick();
    check("nopre_s6", 32'(s), 6);
    req = 8'b0100_1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("nopre_hold6", 32'(s), 6);
    end
    tick();
    check("nopre_s3", 32'(s), 3);
    check("nopre_busy", 32'(busy), 1);

    req = 8'h00;
    tick();
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
